xgmii_udp_rx_filter: RTL



---
 rtl/xgmii_udp_rx_filter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_udp_rx_filter.sv
// XGMII receive-side UDP filter: matches IPv4/UDP frames by MAC, IP, port and magic word,
// then streams the payload into the RX FIFO as tagged 72-bit words with packet/drop counters.
module xgmii_udp_rx_filter #(
   parameter logic [15:0] UDP_PORT          = 16'd3422,
   parameter logic [31:0] MAGIC             = 32'h4E554D41,
   parameter int          MAX_PAYLOAD_WORDS = 16,
   parameter bit          CHECK_DST         = 1'b1
) (
   input  logic        xgmii_clk,
   input  logic        sys_rst,
   input  logic [7:0]  xgmii_rxc,
   input  logic [63:0] xgmii_rxd,
   input  logic [31:0] if_v4addr,
   input  logic [47:0] if_macaddr,
   output logic [71:0] din,
   input  logic        full,
   output logic        wr_en,
   output logic [7:0]  led,
   output logic [31:0] rx_pkt_count,
   output logic [31:0] rx_drop_count
);

   localparam logic [7:0] MAX_W = 8'(MAX_PAYLOAD_WORDS);

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

   state_t      state;
   logic [2:0]  w;
   logic        hdr_ok;
   logic [7:0]  wcnt;
   logic        abort_pend;

   logic        vld_p0;
   logic [63:0] data_p0;
   logic [3:0]  cnt_p0;
   logic        eop_p0;

   logic        vld_p1;
   logic [63:0] data_p1;
   logic [3:0]  cnt_p1;
   logic        eop_p1;
   logic        trunc_p1;

   logic [3:0]  n_lanes;
   logic        field_ok;
   logic        hdr_pass;
   logic [7:0]  wcnt_nx;
   logic        last_word;
   logic        wr_cand;
   logic        wr_abort;
   logic        fail;
   logic        drop_inc;

   function automatic logic [7:0] lane(input logic [63:0] d, input int l);
      return d[8*l +: 8];
   endfunction

   always_comb begin
      n_lanes = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         if (xgmii_rxc[i]) n_lanes = 4'(i);
      end
   end

   // Header fields arrive big-endian; lane 0 carries the lowest-numbered frame byte.
   always_comb begin
      field_ok = (xgmii_rxc == 8'h00);
      case (w)
         3'd1: if (CHECK_DST && {lane(xgmii_rxd, 0), lane(xgmii_rxd, 1), lane(xgmii_rxd, 2),
                                 lane(xgmii_rxd, 3), lane(xgmii_rxd, 4), lane(xgmii_rxd, 5)} != if_macaddr)
                  field_ok = 1'b0;
         3'd2: if ({lane(xgmii_rxd, 4), lane(xgmii_rxd, 5)} != 16'h0800) field_ok = 1'b0;
         3'd3: if (lane(xgmii_rxd, 7) != 8'h11) field_ok = 1'b0;
         3'd4: if (CHECK_DST && {lane(xgmii_rxd, 6), lane(xgmii_rxd, 7)} != if_v4addr[31:16])
                  field_ok = 1'b0;
         3'd5: if ((CHECK_DST && {lane(xgmii_rxd, 0), lane(xgmii_rxd, 1)} != if_v4addr[15:0]) ||
                   {lane(xgmii_rxd, 4), lane(xgmii_rxd, 5)} != UDP_PORT)
                  field_ok = 1'b0;
         3'd6: if ({lane(xgmii_rxd, 2), lane(xgmii_rxd, 3), lane(xgmii_rxd, 4), lane(xgmii_rxd, 5)} != MAGIC)
                  field_ok = 1'b0;
         default: ;
      endcase
   end

   assign hdr_pass  = hdr_ok && field_ok;
   assign wcnt_nx   = wcnt + 8'd1;
   assign last_word = (wcnt_nx == MAX_W);

   // The output word is checked against full in the cycle it is presented, so a blocked
   // word is dropped rather than written; an abort marker owns the port until it goes out.
   assign wr_cand  = vld_p1 && !full && !abort_pend;
   assign wr_abort = abort_pend && !full;
   assign fail     = vld_p1 && full;
   assign drop_inc = fail || (state == HDR && w == 3'd6 && xgmii_rxc != 8'hff &&
                              hdr_pass && (full || abort_pend));
   assign wr_en    = wr_cand || wr_abort;
   assign din      = abort_pend ? {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 64'd0}
                                : {eop_p1, 1'b0, trunc_p1, 1'b0, cnt_p1, data_p1};

   always_ff @(posedge xgmii_clk) begin
      if (sys_rst) begin
         state         <= IDLE;
         w             <= 3'd0;
         hdr_ok        <= 1'b0;
         wcnt          <= 8'd0;
         abort_pend    <= 1'b0;
         vld_p0        <= 1'b0;
         data_p0       <= 64'd0;
         cnt_p0        <= 4'd0;
         eop_p0        <= 1'b0;
         vld_p1        <= 1'b0;
         data_p1       <= 64'd0;
         cnt_p1        <= 4'd0;
         eop_p1        <= 1'b0;
         trunc_p1      <= 1'b0;
         led           <= 8'd0;
         rx_pkt_count  <= 32'd0;
         rx_drop_count <= 32'd0;
      end else begin
         vld_p1 <= 1'b0;
         if (wr_abort) abort_pend <= 1'b0;
         if (wr_cand && eop_p1) rx_pkt_count <= rx_pkt_count + 32'd1;
         if (drop_inc) rx_drop_count <= rx_drop_count + 32'd1;

         // Terminate word of the previous frame still waiting in the hold stage.
         if (state != PAYLOAD && vld_p0) begin
            vld_p1   <= 1'b1;
            data_p1  <= data_p0;
            cnt_p1   <= cnt_p0;
            eop_p1   <= eop_p0;
            trunc_p1 <= 1'b0;
            vld_p0   <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (xgmii_rxc != 8'hff) begin
                  state  <= HDR;
                  w      <= 3'd1;
                  hdr_ok <= 1'b1;
               end
            end
            HDR: begin
               if (xgmii_rxc == 8'hff) begin
                  state <= IDLE;
               end else begin
                  hdr_ok <= hdr_pass;
                  w      <= w + 3'd1;
                  if (w == 3'd6) begin
                     if (hdr_pass && !full && !abort_pend) begin
                        state <= PAYLOAD;
                        wcnt  <= 8'd0;
                     end else begin
                        state <= DROP;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (wcnt == 8'd0 && !vld_p0) led <= lane(xgmii_rxd, 0);
               if (xgmii_rxc == 8'h00) begin
                  data_p0 <= xgmii_rxd;
                  cnt_p0  <= 4'd8;
                  eop_p0  <= 1'b0;
                  vld_p0  <= 1'b1;
                  if (vld_p0) begin
                     vld_p1   <= 1'b1;
                     data_p1  <= data_p0;
                     cnt_p1   <= 4'd8;
                     eop_p1   <= last_word;
                     trunc_p1 <= last_word;
                     wcnt     <= wcnt_nx;
                     if (last_word) begin
                        state  <= DROP;
                        vld_p0 <= 1'b0;
                     end
                  end
               end else begin
                  state <= IDLE;
                  if (vld_p0) begin
                     vld_p1   <= 1'b1;
                     data_p1  <= data_p0;
                     cnt_p1   <= 4'd8;
                     eop_p1   <= last_word || n_lanes == 4'd0;
                     trunc_p1 <= last_word;
                     if (!last_word && n_lanes != 4'd0) begin
                        data_p0 <= xgmii_rxd;
                        cnt_p0  <= n_lanes;
                        eop_p0  <= 1'b1;
                     end else begin
                        vld_p0 <= 1'b0;
                     end
                  end else if (n_lanes != 4'd0) begin
                     vld_p1   <= 1'b1;
                     data_p1  <= xgmii_rxd;
                     cnt_p1   <= n_lanes;
                     eop_p1   <= 1'b1;
                     trunc_p1 <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (xgmii_rxc == 8'hff) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A blocked mid-frame word kills the rest of that frame, including any queued terminate word.
         if (fail) begin
            abort_pend <= 1'b1;
            if (!eop_p1) begin
               vld_p1 <= 1'b0;
               vld_p0 <= 1'b0;
               if (state == PAYLOAD && xgmii_rxc == 8'h00) state <= DROP;
            end
         end
      end
   end

endmodule
